jpeg_stream_sched: RTL and testbench
====================================

Name: jpeg_stream_sched

Overview:
- Frame-level scheduler that sequences one JPEG file onto a single byte stream. Order: header bytes from the header generator, then entropy-coded scan bytes from the compressed-data FIFO, then EOI.
- Inserts the mandatory 0x00 stuff byte after every 0xFF in scan data.
- Sits between the header generator / compressor FIFO and the output sink (UART/Ethernet/DDR writer) with full valid/ready backpressure on every interface.

Parameters:
- HDR_BYTES, 623, exact number of header bytes (SOI through SOS) expected per frame.
- CNT_W, 24, width of the per-frame output byte counter.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- frame_start, in, 1, single-cycle request to emit one frame; sampled only in IDLE.
- busy, out, 1, high from the cycle after an accepted frame_start until the cycle DONE is left.
- hdr_data, in, 8, header byte.
- hdr_valid, in, 1, header byte available.
- hdr_ready, out, 1, header byte consumed when hdr_valid && hdr_ready.
- scan_data, in, 8, compressed scan byte.
- scan_valid, in, 1, scan byte available.
- scan_last, in, 1, marks the final scan byte of the frame.
- scan_ready, out, 1, scan byte consumed when scan_valid && scan_ready.
- jpeg_data, out, 8, output byte.
- jpeg_valid, out, 1, output byte valid.
- jpeg_last, out, 1, high with the final output byte (0xD9).
- jpeg_ready, in, 1, sink accepts the byte when jpeg_valid && jpeg_ready.
- frame_done, out, 1, one-cycle pulse after the final byte is accepted.
- frame_bytes, out, CNT_W, total bytes of the last completed frame; held until the next frame_done.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-frame abandons the frame; no partial EOI is emitted.
- Output register: one byte deep, holds jpeg_data/jpeg_valid/jpeg_last. Let slot_free = !jpeg_valid || jpeg_ready.
  - Load when a byte is generated and slot_free. Otherwise hold all output fields stable.
  - jpeg_valid drops only when the byte is accepted and no new byte loads in that cycle.
- Latency: an upstream byte accepted in cycle N appears on jpeg_data in N+1. Zero bubbles at full throughput.
- Upstream readies:
  - hdr_ready = (state==HDR) && slot_free.
  - scan_ready = (state==SCAN) && slot_free.
  - Both are 0 in all other states.
- States:
  - IDLE: on frame_start go to HDR; clear hdr_cnt and byte_cnt.
  - HDR: each accepted header byte is forwarded and hdr_cnt is incremented. When the HDR_BYTES-th byte is accepted, go to SCAN.
  - SCAN: each accepted scan byte is forwarded.
    - If the byte is 0xFF, go to STUFF and remember scan_last.
    - Else if scan_last, go to EOI_FF.
  - STUFF: emit 0x00 when slot_free without consuming upstream. Then go to EOI_FF if the remembered last flag is set, else back to SCAN.
  - EOI_FF: emit 0xFF when slot_free, then go to EOI_D9.
  - EOI_D9: emit 0xD9 with jpeg_last=1 when slot_free, then go to DONE.
  - DONE: wait until the 0xD9 byte is accepted. Then pulse frame_done, latch frame_bytes = byte_cnt, and go to IDLE.
- No stuffing in HDR or in the EOI marker bytes.
- byte_cnt increments on every output acceptance (jpeg_valid && jpeg_ready), including stuff and EOI bytes. It wraps modulo 2^CNT_W.
- frame_start outside IDLE is ignored; it is not queued.
- frame_start in the same cycle as frame_done is ignored. The state is still DONE in that cycle.
- scan_last on an 0xFF byte: the order is 0xFF, 0x00, 0xFF, 0xD9.
- An empty scan is not supported. At least one scan byte with scan_last is required per frame.
- hdr_valid is ignored outside HDR. Extra header bytes remain upstream unconsumed.
- jpeg_ready held low: the machine stalls in its current state and all upstream readies are 0.

Test Plan:
- HDR_BYTES=4, header 11 22 33 44, scan 01 02 03(last), jpeg_ready=1 -> jpeg_data 11 22 33 44 01 02 03 FF D9 on consecutive cycles; jpeg_last only on D9; frame_done one cycle after D9 accepted; frame_bytes=9.
- Scan AB FF CD(last) -> output ... AB FF 00 CD FF D9; frame_bytes=HDR_BYTES+6.
- Scan FF(last) -> ... FF 00 FF D9; scan_ready low during STUFF and EOI.
- jpeg_ready random 50% duty -> byte sequence identical to the ready=1 case; jpeg_data stable whenever jpeg_valid && !jpeg_ready; no upstream byte consumed while the slot is full.
- frame_start pulsed mid-SCAN and in the frame_done cycle -> ignored; a later frame_start in IDLE starts the next frame, with frame_bytes from the prior frame held until the new frame_done.
- rst_n asserted asynchronously during HDR at hdr_cnt=2 -> jpeg_valid, busy and the readies drop immediately; after release, frame_start yields a full clean frame from header byte 0.

Source files
------------

// File: rtl/jpeg_stream_sched_if.sv
// Stream bundle for jpeg_stream_sched.
//   hdr_*  : header-generator byte stream (valid/ready)
//   scan_* : compressed scan byte stream from the FIFO, with scan_last
//   jpeg_* : scheduled output byte stream towards the sink, with jpeg_last
// master : scheduler side (consumes hdr/scan, produces jpeg)
// slave  : environment side (produces hdr/scan, consumes jpeg)
interface jpeg_stream_sched_if;
  logic [7:0] hdr_data;
  logic       hdr_valid;
  logic       hdr_ready;
  logic [7:0] scan_data;
  logic       scan_valid;
  logic       scan_last;
  logic       scan_ready;
  logic [7:0] jpeg_data;
  logic       jpeg_valid;
  logic       jpeg_last;
  logic       jpeg_ready;

  modport master (
    input  hdr_data, hdr_valid, scan_data, scan_valid, scan_last, jpeg_ready,
    output hdr_ready, scan_ready, jpeg_data, jpeg_valid, jpeg_last
  );

  modport slave (
    output hdr_data, hdr_valid, scan_data, scan_valid, scan_last, jpeg_ready,
    input  hdr_ready, scan_ready, jpeg_data, jpeg_valid, jpeg_last
  );
endinterface

// File: rtl/jpeg_stream_sched.sv
// Frame scheduler: sequences HDR_BYTES header bytes, then scan bytes with
// 0x00 stuffed after every 0xFF, then the EOI marker FF D9, onto one byte
// stream through a single output register.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   frame_start       : request one frame (honoured only in IDLE)
//   busy              : frame in progress
//   frame_done        : one-cycle pulse after the final byte is accepted
//   frame_bytes       : byte count of the last completed frame
//   io (master)       : hdr/scan inputs, jpeg output stream
module jpeg_stream_sched #(
  parameter int HDR_BYTES = 623,
  parameter int CNT_W     = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_bytes,
  jpeg_stream_sched_if.master io
);
  localparam int HC_W = $clog2(HDR_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_SCAN, S_STUFF, S_EOI_FF, S_EOI_D9, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [HC_W-1:0]  hdr_cnt_q, hdr_cnt_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             last_q, last_d;        // scan_last seen on a stuffed 0xFF
  logic [7:0]       jdata_q, jdata_d;
  logic             jvalid_q, jvalid_d;
  logic             jlast_q, jlast_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] fbytes_q, fbytes_d;
  logic             busy_q, busy_d;

  logic       slot_free, acc, gen, gen_last;
  logic [7:0] gen_data;

  assign slot_free     = !jvalid_q || io.jpeg_ready;
  assign acc           = jvalid_q && io.jpeg_ready;
  assign io.hdr_ready  = (state_q == S_HDR)  && slot_free;
  assign io.scan_ready = (state_q == S_SCAN) && slot_free;

  assign io.jpeg_data  = jdata_q;
  assign io.jpeg_valid = jvalid_q;
  assign io.jpeg_last  = jlast_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign frame_bytes   = fbytes_q;

  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    byte_cnt_d = acc ? byte_cnt_q + 1'b1 : byte_cnt_q;
    last_d     = last_q;
    done_d     = 1'b0;
    fbytes_d   = fbytes_q;
    gen        = 1'b0;
    gen_data   = 8'h00;
    gen_last   = 1'b0;

    case (state_q)
      S_IDLE: if (frame_start) begin
        state_d    = S_HDR;
        hdr_cnt_d  = '0;
        byte_cnt_d = '0;
      end
      S_HDR: if (io.hdr_valid && io.hdr_ready) begin
        gen       = 1'b1;
        gen_data  = io.hdr_data;
        hdr_cnt_d = hdr_cnt_q + 1'b1;
        if (hdr_cnt_q == HC_W'(HDR_BYTES - 1)) state_d = S_SCAN;
      end
      S_SCAN: if (io.scan_valid && io.scan_ready) begin
        gen      = 1'b1;
        gen_data = io.scan_data;
        if (io.scan_data == 8'hFF) begin
          state_d = S_STUFF;
          last_d  = io.scan_last;
        end else if (io.scan_last) begin
          state_d = S_EOI_FF;
        end
      end
      S_STUFF: if (slot_free) begin
        gen      = 1'b1;
        gen_data = 8'h00;
        state_d  = last_q ? S_EOI_FF : S_SCAN;
      end
      S_EOI_FF: if (slot_free) begin
        gen      = 1'b1;
        gen_data = 8'hFF;
        state_d  = S_EOI_D9;
      end
      S_EOI_D9: if (slot_free) begin
        gen      = 1'b1;
        gen_data = 8'hD9;
        gen_last = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        // Two phases: wait for D9 acceptance (raise frame_done), then spend
        // the frame_done cycle still in DONE so a coincident frame_start is
        // ignored, and only then return to IDLE.
        if (done_q) begin
          state_d = S_IDLE;
        end else if (acc) begin
          done_d   = 1'b1;
          fbytes_d = byte_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Output slot: load on a generated byte, otherwise hold; valid only
    // drops on acceptance without a reload.
    jdata_d  = jdata_q;
    jlast_d  = jlast_q;
    jvalid_d = jvalid_q;
    if (gen) begin
      jdata_d  = gen_data;
      jlast_d  = gen_last;
      jvalid_d = 1'b1;
    end else if (acc) begin
      jvalid_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      hdr_cnt_q  <= '0;
      byte_cnt_q <= '0;
      last_q     <= 1'b0;
      jdata_q    <= 8'h00;
      jvalid_q   <= 1'b0;
      jlast_q    <= 1'b0;
      done_q     <= 1'b0;
      fbytes_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      last_q     <= last_d;
      jdata_q    <= jdata_d;
      jvalid_q   <= jvalid_d;
      jlast_q    <= jlast_d;
      done_q     <= done_d;
      fbytes_q   <= fbytes_d;
      busy_q     <= busy_d;
    end
  end
endmodule

// File: tb/tb_jpeg_stream_sched.sv
module tb_jpeg_stream_sched;
  localparam int HB = 4;
  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          busy, frame_done;
  logic [CW-1:0] frame_bytes;

  always #5 clk = ~clk;

  jpeg_stream_sched_if bus();

  jpeg_stream_sched #(.HDR_BYTES(HB), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .busy(busy),
    .frame_done(frame_done), .frame_bytes(frame_bytes), .io(bus.master)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  logic [8:0] exp_q[$];          // {last, data}
  logic [7:0] hb[$];
  logic [7:0] sb[$];
  logic [31:0] prev_fb = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  // Drives one frame from hb/sb and scoreboards the output stream.
  task automatic run_frame(input bit full_rate, input bit pulse_mid, input bit pulse_done);
    int hi, si, cyc, first_acc, last_acc, nacc, exp_bytes;
    bit done, fed, seen_last, prev_stall;
    logic [8:0] prev_o, e;
    hi = 0; si = 0; cyc = 0; first_acc = 0; last_acc = 0; nacc = 0;
    done = 0; fed = 0; seen_last = 0; prev_stall = 0; prev_o = '0;
    exp_q.delete();
    foreach (hb[i]) exp_q.push_back({1'b0, hb[i]});
    foreach (sb[i]) begin
      exp_q.push_back({1'b0, sb[i]});
      if (sb[i] == 8'hFF) exp_q.push_back(9'h000);
    end
    exp_q.push_back(9'h0FF);
    exp_q.push_back(9'h1D9);
    exp_bytes = exp_q.size();
    pulse_start();
    fork
      begin
        while (hi < hb.size() && !done) begin
          @(negedge clk); bus.hdr_valid = 1'b1; bus.hdr_data = hb[hi];
          #3; if (bus.hdr_ready) hi++;
        end
        @(negedge clk); bus.hdr_valid = 1'b0;
      end
      begin
        while (si < sb.size() && !done) begin
          @(negedge clk);
          bus.scan_valid = 1'b1; bus.scan_data = sb[si];
          bus.scan_last = (si == sb.size() - 1);
          frame_start = pulse_mid && (si == 1);
          #3; if (bus.scan_ready) si++;
        end
        @(negedge clk); bus.scan_valid = 1'b0; bus.scan_last = 1'b0;
        frame_start = 1'b0; fed = 1;
      end
      begin
        while (!done && cyc < 3000) begin
          @(negedge clk);
          bus.jpeg_ready = full_rate ? 1'b1 : 1'($urandom_range(0, 1));
          #3; cyc++;
          if (prev_stall)
            chk("hold_stable", {23'd0, bus.jpeg_valid, bus.jpeg_last, bus.jpeg_data},
                {23'd0, 1'b1, prev_o});
          if (bus.jpeg_valid && !bus.jpeg_ready)
            chk("no_consume_when_full", {30'd0, bus.hdr_ready, bus.scan_ready}, 32'd0);
          if (fed) chk("scan_ready_after_last", 32'(bus.scan_ready), 32'd0);
          if (seen_last) begin
            chk("frame_done", 32'(frame_done), 32'd1);
            chk("frame_bytes", 32'(frame_bytes), 32'(exp_bytes));
            chk("busy_in_done_cycle", 32'(busy), 32'd1);
            if (pulse_done) frame_start = 1'b1;
            done = 1;
          end else begin
            chk("frame_done_low", 32'(frame_done), 32'd0);
            chk("frame_bytes_held", 32'(frame_bytes), prev_fb);
            if (bus.jpeg_valid && bus.jpeg_ready) begin
              if (exp_q.size() == 0) begin
                chk("extra_byte", {23'd0, bus.jpeg_last, bus.jpeg_data}, 32'h1FF);
              end else begin
                e = exp_q.pop_front();
                chk("byte", {23'd0, bus.jpeg_last, bus.jpeg_data}, {23'd0, e});
              end
              if (nacc == 0) first_acc = cyc;
              last_acc = cyc; nacc++;
              if (bus.jpeg_last) seen_last = 1;
            end
          end
          prev_stall = bus.jpeg_valid && !bus.jpeg_ready;
          prev_o = {bus.jpeg_last, bus.jpeg_data};
        end
        if (!done) begin
          chk("timeout", 32'(cyc), 32'd0);
          done = 1;
        end
      end
    join
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    if (full_rate) chk("consecutive", 32'(last_acc - first_acc), 32'(exp_bytes - 1));
    prev_fb = 32'(exp_bytes);
    @(negedge clk); frame_start = 1'b0;
    #3; chk("idle_after_done", 32'(busy), 32'd0);
    @(negedge clk); #3;
    chk("idle_stays", 32'(busy), 32'd0);
    chk("fb_after_done", 32'(frame_bytes), prev_fb);
  endtask

  initial begin
    int n, cyc;
    bus.hdr_data = '0; bus.hdr_valid = 1'b0;
    bus.scan_data = '0; bus.scan_valid = 1'b0; bus.scan_last = 1'b0;
    bus.jpeg_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_valid", 32'(bus.jpeg_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_fb", 32'(frame_bytes), 32'd0);
    chk("rst_readies", {30'd0, bus.hdr_ready, bus.scan_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    hb = '{8'h11, 8'h22, 8'h33, 8'h44};
    sb = '{8'h01, 8'h02, 8'h03};
    run_frame(1, 0, 0);                 // 9 bytes

    sb = '{8'hAB, 8'hFF, 8'hCD};
    run_frame(1, 0, 0);                 // HB+6

    sb = '{8'hFF};
    run_frame(1, 0, 0);                 // FF 00 FF D9 after header

    sb = '{8'h5A, 8'hFF, 8'hFF, 8'h00, 8'hC3, 8'hFF, 8'h12, 8'h34};
    run_frame(0, 1, 1);                 // random ready, ignored frame_starts

    sb = '{8'h01, 8'h02, 8'h03};
    run_frame(0, 0, 0);                 // same bytes as frame 1 under backpressure

    // Async reset during HDR with hdr_cnt=2
    pulse_start();
    bus.jpeg_ready = 1'b1;
    n = 0; cyc = 0;
    while (n < 2 && cyc < 50) begin
      @(negedge clk); bus.hdr_valid = 1'b1; bus.hdr_data = hb[n];
      #3; cyc++;
      if (bus.hdr_ready) n++;
    end
    chk("hdr_accept_before_rst", 32'(n), 32'd2);
    @(negedge clk); bus.hdr_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(bus.jpeg_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(bus.jpeg_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_hdr_ready", 32'(bus.hdr_ready), 32'd0);
    chk("rst_mid_fb", 32'(frame_bytes), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    prev_fb = 0;
    sb = '{8'h01, 8'h02, 8'h03};
    run_frame(1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
